// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack op encodings, byte counts, stack page and sequencer states.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_PHA = 3'b000,
        OP_PHP = 3'b001,
        OP_PLA = 3'b010,
        OP_PLP = 3'b011,
        OP_JSR = 3'b100,
        OP_RTS = 3'b101,
        OP_INT = 3'b110,
        OP_RTI = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_PULL,
        ST_LAST,
        ST_DONE
    } state_e;

    localparam logic [7:0] STACK_PAGE = 8'h01;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;

    localparam logic [1:0] NB_PHA = 2'd1;
    localparam logic [1:0] NB_PHP = 2'd1;
    localparam logic [1:0] NB_JSR = 2'd2;
    localparam logic [1:0] NB_INT = 2'd3;
    localparam logic [1:0] NB_PLA = 2'd1;
    localparam logic [1:0] NB_PLP = 2'd1;
    localparam logic [1:0] NB_RTS = 2'd2;
    localparam logic [1:0] NB_RTI = 2'd3;

    function automatic logic [1:0] byte_count(input op_e op);
        logic [1:0] n;
        case (op)
            OP_PHA:  n = NB_PHA;
            OP_PHP:  n = NB_PHP;
            OP_JSR:  n = NB_JSR;
            OP_INT:  n = NB_INT;
            OP_PLA:  n = NB_PLA;
            OP_PLP:  n = NB_PLP;
            OP_RTS:  n = NB_RTS;
            default: n = NB_RTI;
        endcase
        return n;
    endfunction

    function automatic logic is_pull(input op_e op);
        return (op == OP_PLA) || (op == OP_PLP) || (op == OP_RTS) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Multi-byte stack push/pull sequencer; drives an external stack pointer block and page-1 memory.
module stack_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] pc,
    input  logic [7:0]  a,
    input  logic [7:0]  p,
    input  logic        brk,
    input  logic [7:0]  sp,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  sp_sel,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        we,
    output logic        re,
    output logic        busy,
    output logic        done,
    output logic [7:0]  res_data,
    output logic [15:0] res_pc,
    output logic        stk_err
);

    state_e      state;
    state_e      state_nx;
    op_e         op_q;
    logic [15:0] pc_q;
    logic [7:0]  a_q;
    logic [7:0]  p_q;
    logic        brk_q;
    logic [1:0]  k;
    logic [7:0]  pull_b0;
    logic [7:0]  pull_b1;
    logic        last_k;

    assign last_k = (k == byte_count(op_q) - 2'd1);

    function automatic logic [7:0] push_byte(input op_e o, input logic [1:0] idx,
                                             input logic [15:0] pcv, input logic [7:0] av,
                                             input logic [7:0] pv, input logic bv);
        logic [7:0] b;
        b = 8'h00;
        case (o)
            OP_PHA: b = av;
            OP_PHP: b = pv | 8'h30;
            OP_JSR, OP_INT: begin
                case (idx)
                    2'd0:    b = pcv[15:8];
                    2'd1:    b = pcv[7:0];
                    default: b = {pv[7:6], 1'b1, bv, pv[3:0]};
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Control state, results and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            k        <= 2'd0;
            res_data <= 8'h00;
            res_pc   <= 16'h0000;
            stk_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                k <= 2'd0;
            end else if (state == ST_PUSH || state == ST_PULL) begin
                k <= k + 2'd1;
            end
            // Final pulled byte arrives in LAST; assemble the results here
            if (state == ST_LAST) begin
                case (op_q)
                    OP_PLA, OP_PLP: res_data <= mem_rdata;
                    OP_RTS:         res_pc   <= {mem_rdata, pull_b0} + 16'd1;
                    OP_RTI: begin
                        res_data <= pull_b0;
                        res_pc   <= {mem_rdata, pull_b1};
                    end
                    default: ;
                endcase
            end
            if ((we || (re && sp_sel == SP_INC)) && sp == 8'h00) begin
                stk_err <= 1'b1;
            end
        end
    end

    // Operands and pipelined read bytes: pull k lands while pull k+1 is issued
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            op_q  <= op_e'(op);
            pc_q  <= pc;
            a_q   <= a;
            p_q   <= p;
            brk_q <= brk;
        end
        if (state == ST_PULL && k != 2'd0) begin
            if (k == 2'd1) begin
                pull_b0 <= mem_rdata;
            end else begin
                pull_b1 <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        sp_sel   = SP_HOLD;
        we       = 1'b0;
        re       = 1'b0;
        addr     = 16'h0000;
        wdata    = 8'h00;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = is_pull(op_e'(op)) ? ST_PULL : ST_PUSH;
                end
            end
            ST_PUSH: begin
                we     = 1'b1;
                sp_sel = SP_DEC;
                addr   = {STACK_PAGE, sp};
                wdata  = push_byte(op_q, k, pc_q, a_q, p_q, brk_q);
                if (last_k) begin
                    state_nx = ST_DONE;
                end
            end
            ST_PULL: begin
                re     = 1'b1;
                sp_sel = SP_INC;
                addr   = {STACK_PAGE, sp};
                if (last_k) begin
                    state_nx = ST_LAST;
                end
            end
            ST_LAST: state_nx = ST_DONE;
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: stack pointer and memory environment, schedule-based reference model.
module tb_stack_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [15:0] pc;
    logic [7:0]  a;
    logic [7:0]  p;
    logic        brk;
    logic [7:0]  sp;
    logic [7:0]  mem_rdata;
    logic [1:0]  sp_sel;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic        busy;
    logic        done;
    logic [7:0]  res_data;
    logic [15:0] res_pc;
    logic        stk_err;

    stack_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .pc(pc), .a(a), .p(p),
        .brk(brk), .sp(sp), .mem_rdata(mem_rdata), .sp_sel(sp_sel), .addr(addr),
        .wdata(wdata), .we(we), .re(re), .busy(busy), .done(done),
        .res_data(res_data), .res_pc(res_pc), .stk_err(stk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: saturating stack pointer (shows the incremented value while pulling) and page-1 memory
    logic [7:0] mem [0:255];
    logic [7:0] sp_reg;
    logic       sp_ld;
    logic [7:0] sp_ld_val;
    logic       mem_ld;
    logic [7:0] mem_ld_addr;
    logic [7:0] mem_ld_val;

    assign sp = (sp_sel == 2'b01) ? sp_reg + 8'd1 : sp_reg;

    always_ff @(posedge clk) begin
        if (sp_ld) sp_reg <= sp_ld_val;
        else if (sp_sel == 2'b10 && sp_reg != 8'h00) sp_reg <= sp_reg - 8'd1;
        else if (sp_sel == 2'b01 && sp_reg != 8'hFF) sp_reg <= sp_reg + 8'd1;
        if (mem_ld) mem[mem_ld_addr] <= mem_ld_val;
        else if (we) mem[addr[7:0]] <= wdata;
        if (re) mem_rdata <= mem[addr[7:0]];
    end

    typedef struct packed {
        logic        we;
        logic        re;
        logic [1:0]  sp_sel;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        busy;
        logic        done;
        logic [7:0]  res_data;
        logic [15:0] res_pc;
        logic        stk_err;
    } obs_t;

    obs_t        sched[$];
    obs_t        cur_exp;
    logic [7:0]  m_res_data;
    logic [15:0] m_res_pc;
    logic        m_err;

    int          n_pass;
    int          n_total;
    int          cyc;
    int          strobes;
    bit          last_done;
    bit          last_busy;
    logic [23:0] wlog[$];
    int          wcyc[$];
    logic [15:0] rlog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic obs_t mk(input logic w, input logic r, input logic [1:0] s,
                                input logic [15:0] ad, input logic [7:0] wd, input logic b,
                                input logic d, input logic [7:0] rd, input logic [15:0] rp,
                                input logic e);
        obs_t o;
        o.we = w; o.re = r; o.sp_sel = s; o.addr = ad; o.wdata = wd; o.busy = b;
        o.done = d; o.res_data = rd; o.res_pc = rp; o.stk_err = e;
        return o;
    endfunction

    function automatic obs_t obs_now();
        return mk(we, re, sp_sel, addr, wdata, busy, done, res_data, res_pc, stk_err);
    endfunction

    function automatic obs_t idle_obs();
        return mk(1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0, m_res_data, m_res_pc, m_err);
    endfunction

    function automatic int nbytes(input logic [2:0] o);
        if (o == 3'd4 || o == 3'd5) return 2;
        if (o == 3'd6 || o == 3'd7) return 3;
        return 1;
    endfunction

    function automatic logic is_pull_op(input logic [2:0] o);
        return (o == 3'd2) || (o == 3'd3) || (o == 3'd5) || (o == 3'd7);
    endfunction

    function automatic logic [23:0] wl(input int i);
        if (wlog.size() > i) return wlog[i];
        return 24'hFFFFFF;
    endfunction

    function automatic logic [15:0] rl(input int i);
        if (rlog.size() > i) return rlog[i];
        return 16'hFFFF;
    endfunction

    task automatic model_reset();
        sched.delete();
        m_err      = 1'b0;
        m_res_data = 8'h00;
        m_res_pc   = 16'h0000;
        cur_exp    = idle_obs();
    endtask

    // Expand one accepted operation into its full cycle-by-cycle expectation list
    task automatic build(input logic [2:0] o, input logic [15:0] pcv, input logic [7:0] av,
                         input logic [7:0] pv, input logic bv, input logic [7:0] sp0);
        int          n;
        int          r;
        logic [7:0]  byt [3];
        logic [7:0]  d [3];
        logic [7:0]  s;
        logic [7:0]  v;
        logic        e;
        logic [7:0]  rd;
        logic [15:0] rp;
        n  = nbytes(o);
        e  = m_err;
        rd = m_res_data;
        rp = m_res_pc;
        if (!is_pull_op(o)) begin
            byt[0] = pcv[15:8];
            byt[1] = pcv[7:0];
            byt[2] = {pv[7:6], 1'b1, bv, pv[3:0]};
            if (o == 3'd0) byt[0] = av;
            if (o == 3'd1) byt[0] = pv | 8'h30;
            for (int i = 0; i < n; i++) begin
                r = int'(sp0) - i;
                if (r < 0) r = 0;
                s = r[7:0];
                sched.push_back(mk(1'b1, 1'b0, 2'b10, {8'h01, s}, byt[i], 1'b1, 1'b0, rd, rp, e));
                if (s == 8'h00) e = 1'b1;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                r = int'(sp0) + i;
                if (r > 255) r = 255;
                v = r[7:0] + 8'd1;
                d[i] = mem[v];
                sched.push_back(mk(1'b0, 1'b1, 2'b01, {8'h01, v}, 8'h00, 1'b1, 1'b0, rd, rp, e));
                if (v == 8'h00) e = 1'b1;
            end
            sched.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 1'b1, 1'b0, rd, rp, e));
            if (o == 3'd2 || o == 3'd3) rd = d[0];
            else if (o == 3'd5) rp = {d[1], d[0]} + 16'd1;
            else begin
                rd = d[0];
                rp = {d[2], d[1]};
            end
        end
        sched.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 1'b1, 1'b1, rd, rp, e));
        m_res_data = rd;
        m_res_pc   = rp;
        m_err      = e;
    endtask

    task automatic model_step();
        if (sched.size() > 0) void'(sched.pop_front());
        else if (start) build(op, pc, a, p, brk, sp_reg);
        cur_exp = (sched.size() > 0) ? sched[0] : idle_obs();
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge
    task automatic tick();
        @(negedge clk);
        chk($sformatf("cycle%0d", cyc), 64'(obs_now()), 64'(cur_exp));
        last_done = done;
        last_busy = busy;
        if (we) begin
            wlog.push_back({addr, wdata});
            wcyc.push_back(cyc);
        end
        if (re) rlog.push_back(addr);
        if (we || re) strobes++;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic set_sp(input logic [7:0] v);
        sp_ld = 1'b1; sp_ld_val = v;
        tick();
        sp_ld = 1'b0;
    endtask

    task automatic set_mem(input logic [7:0] ad, input logic [7:0] v);
        mem_ld = 1'b1; mem_ld_addr = ad; mem_ld_val = v;
        tick();
        mem_ld = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        last_done = 1'b0;
        while (!last_done && lat < 20) begin
            tick();
            lat++;
        end
        if (!last_done) chk("op_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [15:0] pcv, input logic [7:0] av,
                          input logic [7:0] pv, input logic bv, input bit hold, output int lat);
        op = o; pc = pcv; a = av; p = pv; brk = bv; start = 1'b1;
        wlog.delete(); wcyc.delete(); rlog.delete();
        tick();
        if (!hold) start = 1'b0;
        wait_done(lat);
    endtask

    int lat;
    int lat2;
    int sel;
    bit hold;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'd0; pc = 16'h0; a = 8'h0; p = 8'h0; brk = 1'b0;
        sp_ld = 1'b0; sp_ld_val = 8'h0; mem_ld = 1'b0; mem_ld_addr = 8'h0; mem_ld_val = 8'h0;
        n_pass = 0; n_total = 0; cyc = 0; strobes = 0;
        model_reset();
        tick();
        chk("reset_outs", 64'(obs_now()), 64'd0);
        set_sp(8'hFF);
        for (int i = 0; i < 256; i++) set_mem(8'(i), 8'($urandom));
        rst_n = 1'b1;
        tick();

        // JSR 1234 from SP=FF
        set_sp(8'hFF);
        run_op(3'd4, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, lat);
        chk("jsr_lat", 64'(lat), 64'd3);
        chk("jsr_w0", 64'(wl(0)), 64'h01FF12);
        chk("jsr_w1", 64'(wl(1)), 64'h01FE34);
        chk("jsr_consec", 64'(wcyc.size() == 2 ? wcyc[1] - wcyc[0] : 0), 64'd1);
        chk("jsr_sp", 64'(sp_reg), 64'hFD);

        // RTS with 01FE=78, 01FF=56, SP=FD
        set_mem(8'hFE, 8'h78);
        set_mem(8'hFF, 8'h56);
        set_sp(8'hFD);
        run_op(3'd5, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, lat);
        chk("rts_lat", 64'(lat), 64'd4);
        chk("rts_r0", 64'(rl(0)), 64'h01FE);
        chk("rts_r1", 64'(rl(1)), 64'h01FF);
        chk("rts_pc", 64'(res_pc), 64'h5679);
        chk("rts_sp", 64'(sp_reg), 64'hFF);

        // INT pc=C000 p=C3 brk=1
        set_sp(8'hFF);
        run_op(3'd6, 16'hC000, 8'h00, 8'hC3, 1'b1, 1'b0, lat);
        chk("int_w0", 64'(wl(0)), 64'h01FFC0);
        chk("int_w1", 64'(wl(1)), 64'h01FE00);
        chk("int_w2", 64'(wl(2)), 64'h01FDF3);
        chk("int_lat", 64'(lat), 64'd4);

        // PHA at SP=00
        chk("pre_err", 64'(stk_err), 64'd0);
        set_sp(8'h00);
        run_op(3'd0, 16'h0000, 8'hA5, 8'h00, 1'b0, 1'b0, lat);
        chk("pha_err", 64'(stk_err), 64'd1);
        chk("pha_sp", 64'(sp_reg), 64'h00);
        chk("pha_lat", 64'(lat), 64'd2);
        chk("pha_w0", 64'(wl(0)), 64'h0100A5);

        // start held through PHP
        set_sp(8'hF0);
        run_op(3'd1, 16'h0000, 8'h00, 8'h05, 1'b0, 1'b1, lat);
        chk("php_wcount", 64'(wlog.size()), 64'd1);
        chk("php_w0", 64'(wl(0)), 64'h01F035);
        chk("php_lat", 64'(lat), 64'd2);
        tick();
        chk("php_idle_busy", 64'(last_busy), 64'd0);
        start = 1'b0;
        wait_done(lat2);
        chk("php2_lat", 64'(lat2), 64'd2);
        chk("php_wtotal", 64'(wlog.size()), 64'd2);
        chk("php_sp", 64'(sp_reg), 64'hEE);

        // Reset during the second byte of RTI, then a PLA
        set_mem(8'hFE, 8'h5A);
        set_sp(8'hFC);
        op = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_outs", 64'(obs_now()), 64'd0);
        strobes = 0;
        repeat (3) tick();
        chk("rst_strobes", 64'(strobes), 64'd0);
        rst_n = 1'b1;
        run_op(3'd2, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, lat);
        chk("pla_lat", 64'(lat), 64'd3);
        chk("pla_data", 64'(res_data), 64'h5A);
        chk("pla_err", 64'(stk_err), 64'd0);

        // Randomized operations around the stack boundaries
        for (int it = 0; it < 300; it++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) set_sp(8'h00);
            else if (sel == 1) set_sp(8'hFF);
            else if (sel == 2) set_sp(8'($urandom_range(0, 3)));
            else if (sel == 3) set_sp(8'($urandom_range(252, 255)));
            if ($urandom_range(0, 3) == 0) set_mem(8'($urandom), 8'($urandom));
            hold = ($urandom_range(0, 7) == 0);
            run_op(3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), hold, lat);
            if (hold) begin
                tick();
                start = 1'b0;
                wait_done(lat2);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all other ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock, shared with the stack pointer.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request strobe, sampled only in IDLE.
REQ-005 op  in  3  operation: 000 PHA, 001 PHP, 010 PLA, 011 PLP, 100 JSR, 101 RTS, 110 INT, 111 RTI.
REQ-006 pc  in  16  return address to push, latched at start.
REQ-007 a, p  in  8 each  accumulator and status to push, latched at start.
REQ-008 brk  in  1  for INT: B-flag value (bit 4) of the pushed status, latched at start.
REQ-009 sp  in  8  stack pointer value from the stack pointer block.
REQ-010 mem_rdata  in  8  read data, valid the cycle after re.
REQ-011 sp_sel  out  2  stack pointer control: 00 hold, 01 increment (pull), 10 decrement (push).
REQ-012 addr  out  16  memory address; {8'h01, sp} whenever we or re is high, else 16'h0000.
REQ-013 wdata  out  8  push data; we  out  1  write strobe; re  out  1  read strobe.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 res_data  out  8  pulled byte (PLA/PLP) or pulled status (RTI).
REQ-017 res_pc  out  16  pulled return address (RTS/RTI).
REQ-018 stk_err  out  1  sticky flag for a push at sp==00 or a pull with sp==00 while sp_sel==01; cleared only by reset.

Function
REQ-019 The FSM SHALL have the states IDLE, PUSH, PULL, LAST, DONE.
REQ-020 In IDLE, start=1 SHALL latch op/pc/a/p/brk, clear the byte index k, and go to PUSH (ops 000, 001, 100, 110) or PULL (ops 010, 011, 101, 111).
REQ-021 Push byte counts SHALL be PHA=1, PHP=1, JSR=2, INT=3; pull byte counts SHALL be PLA=1, PLP=1, RTS=2, RTI=3.
REQ-022 Push order SHALL be: PHA a; PHP p|8'h30; JSR pc[15:8], pc[7:0]; INT pc[15:8], pc[7:0], {p[7:6],1,brk,p[3:0]}.
REQ-023 Each PUSH cycle SHALL assert we=1 and sp_sel=10 with the byte on wdata, then increment k; after the last byte the FSM goes to DONE.
REQ-024 Each PULL cycle SHALL assert re=1 and sp_sel=01; addr SHALL use the sp input, which is already pre-incremented.
REQ-025 Data for pull k SHALL be captured from mem_rdata in the following cycle; pulls SHALL be pipelined at one per cycle.
REQ-026 After the last read is issued, the FSM SHALL go to LAST to capture the final byte, then to DONE.
REQ-027 Pull order SHALL be: PLA/PLP data; RTS pcl, pch; RTI p, pcl, pch.
REQ-028 For RTS, res_pc SHALL be {pch,pcl}+1 modulo 2^16; for RTI, res_pc SHALL be {pch,pcl} and res_data SHALL be p.
REQ-029 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE; res_data and res_pc SHALL hold until the next pull completes.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 sp_sel SHALL be 00 and we/re SHALL be 0 in IDLE, LAST and DONE.
REQ-032 Latency from the start edge to done SHALL be n+1 cycles for a push and n+2 cycles for a pull (n = byte count).
REQ-033 At a stack boundary, the sequencer SHALL continue the sequence unchanged (the stack pointer saturates) and SHALL set stk_err.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, k=0, busy=0, done=0, we=0, re=0, sp_sel=00, addr=0, wdata=0, res_data=0, res_pc=0, stk_err=0.
REQ-035 A reset mid-operation SHALL abort with no further strobes; a start is accepted on the first edge after release.

Structure
REQ-036 Op encodings, byte-count constants, the stack page constant 8'h01 and the state enumeration SHALL live in a shared package cpu_pkg.
REQ-037 A single sub-module, stack_pointer, SHALL be instantiated alongside this block at the next level (not inside it); the sequencer itself SHALL have no sub-modules.

Verification
REQ-038 SP=FF, JSR with pc=1234 -> writes 12@01FF and 34@01FE in consecutive cycles, SP=FD, done at cycle 3.
REQ-039 Memory 01FE=78, 01FF=56, SP=FD, RTS -> reads at 01FE and 01FF, res_pc=5679, done at cycle 4, SP=FF.
REQ-040 INT with pc=C000, p=C3, brk=1, SP=FF -> writes C0, 00, F3 at 01FF..01FD.
REQ-041 SP=00, PHA -> stk_err=1, SP stays 00, done still pulses.
REQ-042 rst_n low during the second byte of RTI -> outputs zero immediately, no further we/re; a new PLA after release completes normally.
REQ-043 start held high through a PHP -> exactly one push; a second op starts only after the DONE cycle.
